button_debounce: RTL
====================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2_000_000; consecutive stable cycles required to accept a level change (10 ms at 200 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, minimum 2; synchronizer flip-flop depth.
REQ-003 SHALL have parameter HOLD_CYCLES, default 200_000_000; press duration before auto-repeat starts (1 s).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 100_000_000; auto-repeat period (0.5 s).
REQ-005 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset, synchronous, active-high.
REQ-007 SHALL have port btn_in, input, 1 bit; raw asynchronous push-button (GPIO_SW), high = pressed.
REQ-008 SHALL have port btn_level, output, 1 bit; debounced button level.
REQ-009 SHALL have port btn_press, output, 1 bit; one-cycle pulse on an accepted press, and on each auto-repeat tick.
REQ-010 SHALL have port btn_release, output, 1 bit; one-cycle pulse on an accepted release.

Function
REQ-011 SHALL pass btn_in through SYNC_STAGES flops; the last stage is sync_q, and all logic uses only sync_q.
REQ-012 SHALL implement FSM states IDLE (released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 SHALL do IDLE->PRESS_WAIT when sync_q=1, clearing cnt to 0.
REQ-014 SHALL increment cnt each cycle in PRESS_WAIT while sync_q=1, and return to IDLE the cycle sync_q=0 (glitch rejected, no pulse).
REQ-015 SHALL go PRESS_WAIT->PRESSED when cnt==DEBOUNCE_CYCLES-1 with sync_q=1; the next cycle btn_level=1 and btn_press=1 for exactly one cycle.
REQ-016 SHALL make PRESSED/RELEASE_WAIT symmetric: PRESSED->RELEASE_WAIT on sync_q=0; RELEASE_WAIT returns to PRESSED on sync_q=1; RELEASE_WAIT->IDLE at cnt==DEBOUNCE_CYCLES-1, then btn_level=0 and btn_release=1 for one cycle.
REQ-017 SHALL give end-to-end latency from the first clk edge sampling a stable btn_in change to btn_level change of SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
REQ-018 SHALL size cnt as $clog2 of the max of DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES; it never wraps and saturates if untouched.
REQ-019 SHALL never assert btn_press and btn_release in the same cycle.
REQ-020 SHALL keep btn_level unchanged by bounces shorter than DEBOUNCE_CYCLES, however many there are.

Reset
REQ-021 SHALL, on rst=1 at a clk edge, set the state to IDLE, cnt and the hold/repeat counters to 0, synchronizer flops to 0, and btn_level, btn_press and btn_release to 0.
REQ-022 SHALL, on reset mid-PRESSED, emit no btn_release; a still-held button is re-debounced from IDLE and produces a fresh btn_press.
REQ-023 SHALL give rst priority over every other event in the same cycle.

Configuration
REQ-024 SHALL, with macro BUTTON_DEBOUNCE_REPEAT_EN defined, count PRESSED cycles in hold_cnt (reset on entry to PRESSED).
REQ-025 SHALL, with the macro defined, pulse btn_press at hold_cnt==HOLD_CYCLES and every REPEAT_CYCLES after that while the state stays PRESSED; RELEASE_WAIT freezes the repeat counters and a return to PRESSED resumes them.
REQ-026 SHALL, without the macro, emit btn_press only once per accepted press, leave HOLD_CYCLES and REPEAT_CYCLES unused, and synthesize no hold/repeat counters.

Structure
REQ-027 SHALL place in package button_pkg the FSM state enum (btn_state_t) and the default constants DEBOUNCE_10MS_200MHZ, HOLD_1S_200MHZ and REPEAT_500MS_200MHZ.
REQ-028 SHALL contain one sub-module, sync_ff (parameterized depth, reset to 0), holding the synchronizer.

Verification (benches override DEBOUNCE_CYCLES=8, HOLD_CYCLES=40, REPEAT_CYCLES=16)
REQ-029 SHALL verify: btn_in 0->1 held -> btn_level=1 and one btn_press exactly 11 cycles after first sample.
REQ-030 SHALL verify: btn_in high for 5 cycles, repeated 10 times -> btn_level stays 0, with no pulses.
REQ-031 SHALL verify: pressed, then a 3-cycle low glitch -> no btn_release, btn_level stays 1.
REQ-032 SHALL verify: release after press -> btn_release once, 11 cycles after the fall; btn_press never coincides with it.
REQ-033 SHALL verify: rst pulsed while PRESSED with btn_in high -> outputs 0 next cycle, no release pulse, then btn_press again 11 cycles after rst deasserts.
REQ-034 SHALL verify, with BUTTON_DEBOUNCE_REPEAT_EN: hold 100 cycles after acceptance -> btn_press at +0, +40, +56, +72, +88; without the macro -> only +0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and 200 MHz timing constants for the push-button debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_10MS_200MHZ = 2_000_000;
    localparam int HOLD_1S_200MHZ       = 200_000_000;
    localparam int REPEAT_500MS_200MHZ  = 100_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input; clears to 0 on reset.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer with registered level and press/release pulses.
// Optional auto-repeat of btn_press while held: define BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_200MHZ,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = HOLD_1S_200MHZ,
    parameter int REPEAT_CYCLES   = REPEAT_500MS_200MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int                CNT_W    = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, max3(REPEAT_CYCLES, 2, 2)));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       w_sync_q;
    logic       w_entry;
    logic       w_tick;
    btn_state_t r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic       r_level, r_press, r_release;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (btn_in),
        .o_q   (w_sync_q)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_sync_q) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_sync_q)               w_state_next = IDLE;
                else if (r_cnt == CNT_LAST)  w_state_next = PRESSED;
                else                         w_cnt_next   = r_cnt + 1'b1;
            end
            PRESSED: begin
                if (!w_sync_q) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_sync_q)                w_state_next = PRESSED;
                else if (r_cnt == CNT_LAST)  w_state_next = IDLE;
                else                         w_cnt_next   = r_cnt + 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_entry = (r_state == PRESS_WAIT) && (w_state_next == PRESSED);

    // Outputs trail the state by one cycle; comparing against the previous
    // level turns state changes into single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= (r_state == PRESSED) || (r_state == RELEASE_WAIT);
            r_press   <= ((r_state == PRESSED) && !r_level) || w_tick;
            r_release <= (r_state == IDLE) && r_level;
        end
    end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int               HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic [REP_W-1:0]  r_rep_cnt;

    // hold_cnt parks at HOLD_CYCLES; from then on rep_cnt spaces the ticks.
    always_ff @(posedge clk) begin
        if (rst || w_entry) begin
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
        end else if (r_state == PRESSED) begin
            if (r_hold_cnt != HOLD_MAX)   r_hold_cnt <= r_hold_cnt + 1'b1;
            else if (r_rep_cnt == REP_LAST) r_rep_cnt <= '0;
            else                          r_rep_cnt  <= r_rep_cnt + 1'b1;
        end
    end

    assign w_tick = (r_state == PRESSED) && (r_hold_cnt == HOLD_MAX) && (r_rep_cnt == '0);
`else
    assign w_tick = 1'b0;
`endif

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule
